// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU unit: restoring shift-subtract, one quotient bit per cycle.
// resultE = {remainder, quotient}; stall_divE holds the front of the pipeline while busy.
module div_seq #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        startE,
  input  logic        signedE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        annul,
  output logic        stall_divE,
  output logic        readyE,
  output logic [63:0] resultE
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_quo;
  logic [31:0]     r_rem;
  logic [31:0]     r_dvs;
  logic            r_qsign;
  logic            r_rsign;
  logic [63:0]     r_result;

  logic            w_accept;
  logic            w_dbz;
  logic            w_done_ok;
  logic [32:0]     w_a_ext;
  logic [32:0]     w_b_ext;
  logic [31:0]     w_a_abs;
  logic [31:0]     w_b_abs;
  logic [32:0]     w_shift;
  logic [33:0]     w_diff;
  logic            w_fits;
  logic [31:0]     w_quo_fix;
  logic [31:0]     w_rem_fix;
  logic [63:0]     w_final;

  assign w_accept  = (r_state == StIdle) & startE & ~annul;
  assign w_dbz     = (srcbE == 32'd0);
  assign w_done_ok = (r_state == StDone) & ~annul;

  // 33-bit sign extension keeps |0x80000000| representable as an unsigned magnitude.
  assign w_a_ext = {signedE & srcaE[31], srcaE};
  assign w_b_ext = {signedE & srcbE[31], srcbE};
  assign w_a_abs = 32'(w_a_ext[32] ? (33'd0 - w_a_ext) : w_a_ext);
  assign w_b_abs = 32'(w_b_ext[32] ? (33'd0 - w_b_ext) : w_b_ext);

  // Partial remainder is 33 bits after the shift; the extra diff bit is the borrow.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_fits  = ~w_diff[33];

  assign w_quo_fix = r_qsign ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_rsign ? (32'd0 - r_rem) : r_rem;
  assign w_final   = {w_rem_fix, w_quo_fix};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_dbz ? StDone : StBusy;
      end
      StBusy: begin
        if (annul)                 w_state_next = StIdle;
        else if (r_cnt == LastCnt) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    // Gated by resetn so a held startE cannot raise stall while in reset.
    stall_divE = resetn & ~annul &
                 (((r_state == StIdle) & startE) | (r_state == StBusy));
    readyE     = w_done_ok;
    resultE    = w_done_ok ? w_final : r_result;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        if (w_dbz) begin
          r_quo   <= 32'hFFFF_FFFF;
          r_rem   <= srcaE;
          r_qsign <= 1'b0;
          r_rsign <= 1'b0;
        end else begin
          r_quo   <= w_a_abs;
          r_rem   <= '0;
          r_dvs   <= w_b_abs;
          r_qsign <= signedE & (srcaE[31] ^ srcbE[31]);
          r_rsign <= signedE & srcaE[31];
        end
      end else if (r_state == StBusy) begin
        r_cnt <= r_cnt + 1'b1;
        r_quo <= {r_quo[30:0], w_fits};
        r_rem <= w_fits ? w_diff[31:0] : w_shift[31:0];
      end
      if (w_done_ok) r_result <= w_final;
    end
  end

endmodule
